// File: rtl/mdio_command_queue.sv
// MDIO command queue: a FIFO of register read/write commands feeding a single-outstanding
// transceiver handshake, with a bounded wait for the transceiver to go busy after each strobe.
module mdio_command_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned START_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_push,
    input  logic        cmd_is_write,
    input  logic [4:0]  cmd_md_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wr_data,
    output logic        queue_full,
    output logic        queue_empty,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic [4:0]  phy_md_addr,
    output logic [4:0]  phy_reg_addr,
    output logic [15:0] phy_wr_data,
    output logic        phy_reg_wr,
    output logic        phy_reg_rd,
    input  logic        mgmt_busy,
    input  logic [15:0] phy_rd_data,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic [4:0]  result_reg_addr,
    output logic        timeout,
    output logic        engine_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

    typedef struct packed {
        logic        is_write;
        logic [4:0]  md_addr;
        logic [4:0]  reg_addr;
        logic [15:0] wr_data;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitStart, StWaitDone} state_e;

    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    state_e        state_q;
    logic          is_write_q;
    logic [CW-1:0] cnt_q;

    entry_t head;
    entry_t cmd_in;
    logic   pop;
    logic   push_ok;
    logic   push_drop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign queue_empty = (wr_ptr_q == rd_ptr_q);
    assign queue_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head   = mem_q[rd_ptr_q[AW-1:0]];
    assign cmd_in = {cmd_is_write, cmd_md_addr, cmd_reg_addr, cmd_wr_data};

    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign pop       = (state_q == StIdle) && !queue_empty && !mgmt_busy;
    assign push_ok   = cmd_push && (!queue_full || pop);
    assign push_drop = cmd_push && queue_full && !pop;

    assign engine_busy = !queue_empty || (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            // A dropped push wins over a simultaneous clear.
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            is_write_q      <= 1'b0;
            cnt_q           <= '0;
            phy_md_addr     <= '0;
            phy_reg_addr    <= '0;
            phy_wr_data     <= '0;
            phy_reg_wr      <= 1'b0;
            phy_reg_rd      <= 1'b0;
            result_valid    <= 1'b0;
            result_data     <= '0;
            result_reg_addr <= '0;
            timeout         <= 1'b0;
        end else begin
            phy_reg_wr   <= 1'b0;
            phy_reg_rd   <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        is_write_q   <= head.is_write;
                        phy_md_addr  <= head.md_addr;
                        phy_reg_addr <= head.reg_addr;
                        phy_wr_data  <= head.wr_data;
                        // Strobe is registered so it is high exactly while in StIssue.
                        phy_reg_wr   <= head.is_write;
                        phy_reg_rd   <= !head.is_write;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWaitStart;
                end
                StWaitStart: begin
                    if (mgmt_busy) begin
                        state_q <= StWaitDone;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                            timeout <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                StWaitDone: begin
                    if (!mgmt_busy) begin
                        state_q <= StIdle;
                        if (!is_write_q) begin
                            result_data     <= phy_rd_data;
                            result_reg_addr <= phy_reg_addr;
                            result_valid    <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_command_queue.sv
// Bench for mdio_command_queue: directed scenarios plus a randomized run checked against a
// queue-level model of the command stream and a simple transceiver busy responder.
module tb_mdio_command_queue;

    localparam int unsigned DEPTH         = 4;
    localparam int unsigned START_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_push = 1'b0;
    logic        cmd_is_write = 1'b0;
    logic [4:0]  cmd_md_addr = '0;
    logic [4:0]  cmd_reg_addr = '0;
    logic [15:0] cmd_wr_data = '0;
    logic        queue_full;
    logic        queue_empty;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic [4:0]  phy_md_addr;
    logic [4:0]  phy_reg_addr;
    logic [15:0] phy_wr_data;
    logic        phy_reg_wr;
    logic        phy_reg_rd;
    logic        mgmt_busy = 1'b0;
    logic [15:0] phy_rd_data = '0;
    logic        result_valid;
    logic [15:0] result_data;
    logic [4:0]  result_reg_addr;
    logic        timeout;
    logic        engine_busy;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned cyc;
        logic        wr;
        logic        rd;
        logic [4:0]  md;
        logic [4:0]  ra;
        logic [15:0] data;
    } strobe_t;

    typedef struct {
        int unsigned cyc;
        logic [15:0] data;
        logic [4:0]  ra;
    } result_t;

    typedef struct {
        logic        wr;
        logic [4:0]  md;
        logic [4:0]  ra;
        logic [15:0] data;
    } cmd_t;

    strobe_t     strobes[$];
    result_t     results[$];
    int unsigned timeouts[$];
    logic [15:0] rd_sent[$];

    // Transceiver responder controls
    int unsigned phy_delay = 2;
    int unsigned phy_len = 3;
    int unsigned ignore_n = 0;
    bit          phy_rand = 1'b0;
    bit          force_busy = 1'b0;
    bit          rd_fixed_en = 1'b0;
    logic [15:0] rd_fixed = '0;
    int unsigned delay_left = 0;
    int unsigned busy_left = 0;
    int unsigned len_pend = 0;

    mdio_command_queue #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_push        (cmd_push),
        .cmd_is_write    (cmd_is_write),
        .cmd_md_addr     (cmd_md_addr),
        .cmd_reg_addr    (cmd_reg_addr),
        .cmd_wr_data     (cmd_wr_data),
        .queue_full      (queue_full),
        .queue_empty     (queue_empty),
        .overflow        (overflow),
        .overflow_clr    (overflow_clr),
        .phy_md_addr     (phy_md_addr),
        .phy_reg_addr    (phy_reg_addr),
        .phy_wr_data     (phy_wr_data),
        .phy_reg_wr      (phy_reg_wr),
        .phy_reg_rd      (phy_reg_rd),
        .mgmt_busy       (mgmt_busy),
        .phy_rd_data     (phy_rd_data),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_reg_addr (result_reg_addr),
        .timeout         (timeout),
        .engine_busy     (engine_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event logger, sampled mid-cycle
    always @(negedge clk) begin
        if (phy_reg_wr || phy_reg_rd)
            strobes.push_back('{cyc, phy_reg_wr, phy_reg_rd, phy_md_addr, phy_reg_addr, phy_wr_data});
        if (result_valid) results.push_back('{cyc, result_data, result_reg_addr});
        if (timeout) timeouts.push_back(cyc);
    end

    // Busy responder: busy rises phy_delay cycles after a strobe and stays high phy_len cycles.
    always @(negedge clk) begin
        int unsigned b, d, l, ig;
        logic [15:0] v;
        b = busy_left;
        d = delay_left;
        l = len_pend;
        ig = ignore_n;
        if (b > 0) b--;
        if (d > 0) begin
            d--;
            if (d == 0) b = l;
        end
        if (phy_reg_wr || phy_reg_rd) begin
            if (ig > 0) begin
                ig--;
            end else begin
                d = phy_rand ? $urandom_range(4, 1) : phy_delay;
                l = phy_rand ? $urandom_range(5, 1) : phy_len;
            end
            if (phy_reg_rd) begin
                v = rd_fixed_en ? rd_fixed : 16'($urandom);
                phy_rd_data <= v;
                rd_sent.push_back(v);
            end
        end
        if (!rst_n) begin
            b = 0;
            d = 0;
        end
        busy_left  <= b;
        delay_left <= d;
        len_pend   <= l;
        ignore_n   <= ig;
        mgmt_busy  <= force_busy || (b > 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cmd_push = 1'b0;
        overflow_clr = 1'b0;
        force_busy = 1'b0;
        phy_rand = 1'b0;
        rd_fixed_en = 1'b0;
        ignore_n = 0;
        phy_delay = 2;
        phy_len = 3;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        strobes.delete();
        results.delete();
        timeouts.delete();
        rd_sent.delete();
    endtask

    task automatic push(input logic w, input logic [4:0] md, input logic [4:0] ra,
                        input logic [15:0] d);
        cmd_push = 1'b1;
        cmd_is_write = w;
        cmd_md_addr = md;
        cmd_reg_addr = ra;
        cmd_wr_data = d;
        tick();
        cmd_push = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while ((engine_busy || mgmt_busy) && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (engine_busy || mgmt_busy) begin
            errors++;
            $display("FAIL %s_drain: engine_busy=%0b after %0d cycles, required 0", name,
                     engine_busy, n);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_push = 1'b1;
        cmd_is_write = 1'b1;
        cmd_md_addr = 5'h1f;
        tick();
        tick();
        cmd_push = 1'b0;
        checks++;
        if ({queue_empty, queue_full, overflow} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: empty/full/ovf=%b, required 100",
                     {queue_empty, queue_full, overflow});
        end
        checks++;
        if ({phy_reg_wr, phy_reg_rd, result_valid, timeout} !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, required 0000",
                     {phy_reg_wr, phy_reg_rd, result_valid, timeout});
        end
        checks++;
        if ({phy_md_addr, phy_reg_addr, phy_wr_data} !== 26'h0) begin
            errors++;
            $display("FAIL reset_phy_out: got %h, required 0",
                     {phy_md_addr, phy_reg_addr, phy_wr_data});
        end
        checks++;
        if ({result_data, result_reg_addr} !== 21'h0) begin
            errors++;
            $display("FAIL reset_result: got %h, required 0", {result_data, result_reg_addr});
        end
        checks++;
        if (engine_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_engine_busy: got %b, required 0", engine_busy);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        phy_delay = 2;
        phy_len = 10;
        rd_fixed_en = 1'b1;
        rd_fixed = 16'hBEEF;
        push(1'b0, 5'h01, 5'h02, 16'h0000);
        wait_idle(100, "single_read");
        checks++;
        if (strobes.size() !== 1) begin
            errors++;
            $display("FAIL sr_strobe_count: got %0d, required 1", strobes.size());
        end else begin
            checks++;
            if ({strobes[0].wr, strobes[0].rd, strobes[0].md, strobes[0].ra} !==
                {1'b0, 1'b1, 5'h01, 5'h02}) begin
                errors++;
                $display("FAIL sr_strobe: wr=%b rd=%b md=%h ra=%h, required 0 1 01 02",
                         strobes[0].wr, strobes[0].rd, strobes[0].md, strobes[0].ra);
            end
        end
        checks++;
        if (results.size() !== 1) begin
            errors++;
            $display("FAIL sr_result_count: got %0d, required 1", results.size());
        end else begin
            checks++;
            if (results[0].data !== 16'hBEEF || results[0].ra !== 5'h02) begin
                errors++;
                $display("FAIL sr_result: data=%h ra=%h, required BEEF 02", results[0].data,
                         results[0].ra);
            end
            // Busy is high from strobe+2 for 10 cycles; completion cannot precede its fall.
            checks++;
            if (strobes.size() == 1 && results[0].cyc < strobes[0].cyc + 12) begin
                errors++;
                $display("FAIL sr_result_timing: result at +%0d, required >= +12",
                         results[0].cyc - strobes[0].cyc);
            end
        end
        checks++;
        if (result_data !== 16'hBEEF || timeouts.size() !== 0) begin
            errors++;
            $display("FAIL sr_hold: result_data=%h timeouts=%0d, required BEEF 0", result_data,
                     timeouts.size());
        end
    endtask

    task automatic test_fill_overflow();
        int unsigned rel;
        apply_reset();
        phy_delay = 2;
        phy_len = 3;
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(1'b1, 5'(i + 3), 5'(i + 8), 16'hA000 + 16'(i));
        checks++;
        if (queue_full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b ovf=%b, required 1 0", queue_full, overflow);
        end
        push(1'b1, 5'h09, 5'h09, 16'h5555);
        checks++;
        if (overflow !== 1'b1 || queue_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow_set: ovf=%b full=%b, required 1 1", overflow, queue_full);
        end
        overflow_clr = 1'b1;
        push(1'b1, 5'h0a, 5'h0a, 16'h6666);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_set_wins: ovf=%b, required 1", overflow);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_overflow_clr: ovf=%b, required 0", overflow);
        end
        checks++;
        if (strobes.size() !== 0) begin
            errors++;
            $display("FAIL fill_no_strobe_busy: strobes=%0d, required 0", strobes.size());
        end
        rel = cyc;
        force_busy = 1'b0;
        wait_idle(300, "fill");
        checks++;
        if (strobes.size() !== 4) begin
            errors++;
            $display("FAIL fill_strobe_count: got %0d, required 4", strobes.size());
        end else begin
            checks++;
            if (strobes[0].cyc <= rel || strobes[0].cyc > rel + 2) begin
                errors++;
                $display("FAIL fill_first_strobe: at +%0d after release, required +1..+2",
                         strobes[0].cyc - rel);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({strobes[i].wr, strobes[i].rd, strobes[i].md, strobes[i].ra, strobes[i].data}
                    !== {1'b1, 1'b0, 5'(i + 3), 5'(i + 8), 16'hA000 + 16'(i)}) begin
                    errors++;
                    $display("FAIL fill_order[%0d]: md=%h ra=%h data=%h, required %h %h %h", i,
                             strobes[i].md, strobes[i].ra, strobes[i].data, 5'(i + 3),
                             5'(i + 8), 16'hA000 + 16'(i));
                end
                // Issue, 2 wait-start, 3 busy, one idle: strobes 7 cycles apart.
                if (i > 0) begin
                    checks++;
                    if (strobes[i].cyc - strobes[i-1].cyc != 7) begin
                        errors++;
                        $display("FAIL fill_spacing[%0d]: got %0d, required 7", i,
                                 strobes[i].cyc - strobes[i-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        ignore_n = 1;
        phy_delay = 2;
        phy_len = 2;
        push(1'b0, 5'h04, 5'h05, 16'h0000);
        push(1'b1, 5'h06, 5'h07, 16'h1234);
        wait_idle(200, "timeout");
        checks++;
        if (timeouts.size() !== 1 || strobes.size() !== 2) begin
            errors++;
            $display("FAIL to_counts: timeouts=%0d strobes=%0d, required 1 2", timeouts.size(),
                     strobes.size());
        end else begin
            checks++;
            if (timeouts[0] - strobes[0].cyc != START_TIMEOUT + 1) begin
                errors++;
                $display("FAIL to_latency: got %0d, required %0d", timeouts[0] - strobes[0].cyc,
                         START_TIMEOUT + 1);
            end
            checks++;
            if ({strobes[1].wr, strobes[1].md, strobes[1].ra, strobes[1].data} !==
                {1'b1, 5'h06, 5'h07, 16'h1234} || strobes[0].rd !== 1'b1) begin
                errors++;
                $display("FAIL to_next_cmd: wr=%b md=%h ra=%h data=%h, required 1 06 07 1234",
                         strobes[1].wr, strobes[1].md, strobes[1].ra, strobes[1].data);
            end
            checks++;
            if (strobes[1].cyc - strobes[0].cyc != START_TIMEOUT + 2) begin
                errors++;
                $display("FAIL to_next_spacing: got %0d, required %0d",
                         strobes[1].cyc - strobes[0].cyc, START_TIMEOUT + 2);
            end
        end
        checks++;
        if (results.size() !== 0) begin
            errors++;
            $display("FAIL to_no_result: got %0d results, required 0", results.size());
        end
    endtask

    task automatic test_push_pop_full();
        apply_reset();
        phy_delay = 2;
        phy_len = 2;
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(1'b1, 5'(i), 5'(i + 16), 16'hB000 + 16'(i));
        checks++;
        if (queue_full !== 1'b1) begin
            errors++;
            $display("FAIL ppf_full_before: full=%b, required 1", queue_full);
        end
        force_busy = 1'b0;
        push(1'b1, 5'h14, 5'h15, 16'hC0DE);
        checks++;
        if (overflow !== 1'b0 || queue_full !== 1'b1) begin
            errors++;
            $display("FAIL ppf_accept: ovf=%b full=%b, required 0 1", overflow, queue_full);
        end
        wait_idle(300, "ppf");
        checks++;
        if (strobes.size() !== 5) begin
            errors++;
            $display("FAIL ppf_strobe_count: got %0d, required 5", strobes.size());
        end else begin
            checks++;
            if ({strobes[4].md, strobes[4].ra, strobes[4].data} !== {5'h14, 5'h15, 16'hC0DE} ||
                strobes[3].data !== 16'hB003) begin
                errors++;
                $display("FAIL ppf_last: md=%h ra=%h data=%h, required 14 15 C0DE",
                         strobes[4].md, strobes[4].ra, strobes[4].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int unsigned seen;
        apply_reset();
        phy_delay = 2;
        phy_len = 20;
        for (int i = 0; i < 3; i++) push(1'b0, 5'(i + 1), 5'(i + 1), 16'h0);
        while (strobes.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checks++;
        if (mgmt_busy !== 1'b1 || engine_busy !== 1'b1 || queue_empty !== 1'b0) begin
            errors++;
            $display("FAIL rm_pre: busy=%b engine=%b empty=%b, required 1 1 0", mgmt_busy,
                     engine_busy, queue_empty);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({queue_empty, queue_full, overflow, phy_reg_wr, phy_reg_rd, result_valid, timeout,
             engine_busy} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL rm_reset_flags: got %b, required 10000000",
                     {queue_empty, queue_full, overflow, phy_reg_wr, phy_reg_rd, result_valid,
                      timeout, engine_busy});
        end
        checks++;
        if ({phy_md_addr, phy_reg_addr, phy_wr_data, result_data, result_reg_addr} !== 47'h0)
        begin
            errors++;
            $display("FAIL rm_reset_data: got %h, required 0",
                     {phy_md_addr, phy_reg_addr, phy_wr_data, result_data, result_reg_addr});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        seen = strobes.size();
        repeat (30) tick();
        checks++;
        if (strobes.size() != seen || results.size() !== 0) begin
            errors++;
            $display("FAIL rm_after_release: new strobes=%0d results=%0d, required 0 0",
                     strobes.size() - seen, results.size());
        end
        checks++;
        if (queue_empty !== 1'b1 || engine_busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_idle: empty=%b engine=%b, required 1 0", queue_empty, engine_busy);
        end
    endtask

    task automatic test_random();
        cmd_t exp[$];
        cmd_t rds[$];
        cmd_t c;
        apply_reset();
        phy_rand = 1'b1;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(1, 0) == 1 && (exp.size() - strobes.size()) < int'(DEPTH)) begin
                c.wr = 1'($urandom);
                c.md = 5'($urandom);
                c.ra = 5'($urandom);
                c.data = 16'($urandom);
                exp.push_back(c);
                if (!c.wr) rds.push_back(c);
                push(c.wr, c.md, c.ra, c.data);
            end else begin
                tick();
            end
        end
        wait_idle(1000, "random");
        checks++;
        if (strobes.size() != exp.size()) begin
            errors++;
            $display("FAIL rnd_strobe_count: got %0d, required %0d", strobes.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (strobes[i].wr !== exp[i].wr || strobes[i].rd !== !exp[i].wr ||
                    strobes[i].md !== exp[i].md || strobes[i].ra !== exp[i].ra ||
                    (exp[i].wr && strobes[i].data !== exp[i].data)) begin
                    errors++;
                    $display("FAIL rnd_cmd[%0d]: wr=%b md=%h ra=%h data=%h, required %b %h %h %h",
                             i, strobes[i].wr, strobes[i].md, strobes[i].ra, strobes[i].data,
                             exp[i].wr, exp[i].md, exp[i].ra, exp[i].data);
                end
            end
        end
        checks++;
        if (results.size() != rds.size() || rd_sent.size() != rds.size()) begin
            errors++;
            $display("FAIL rnd_result_count: got %0d, required %0d", results.size(), rds.size());
        end else begin
            foreach (rds[j]) begin
                checks++;
                if (results[j].data !== rd_sent[j] || results[j].ra !== rds[j].ra) begin
                    errors++;
                    $display("FAIL rnd_result[%0d]: data=%h ra=%h, required %h %h", j,
                             results[j].data, results[j].ra, rd_sent[j], rds[j].ra);
                end
            end
        end
        checks++;
        if (overflow !== 1'b0 || timeouts.size() !== 0) begin
            errors++;
            $display("FAIL rnd_clean: ovf=%b timeouts=%0d, required 0 0", overflow,
                     timeouts.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fill_overflow();
        test_timeout();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_command_queue.md
MDIO_COMMAND_QUEUE -- requirements
Module: mdio_command_queue

Interface
REQ-001 Parameter DEPTH, default 4, command queue depth in entries; SHALL be a power of two, 2..16.
REQ-002 Parameter START_TIMEOUT, default 15, maximum cycles to wait for transceiver busy to assert after a strobe.
REQ-003 clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_push  in  1  enqueue one command this cycle.
REQ-006 cmd_is_write  in  1  1 = register write, 0 = register read.
REQ-007 cmd_md_addr  in  5  PHY address.
REQ-008 cmd_reg_addr  in  5  PHY register address.
REQ-009 cmd_wr_data  in  16  write payload; ignored for reads.
REQ-010 queue_full  out  1  no free entry.
REQ-011 queue_empty  out  1  no pending entry.
REQ-012 overflow  out  1  sticky; a push arrived while queue_full was 1.
REQ-013 overflow_clr  in  1  clears overflow.
REQ-014 phy_md_addr, phy_reg_addr  out  5 each  address fields to the transceiver, held stable from strobe to completion.
REQ-015 phy_wr_data  out  16  write payload to the transceiver.
REQ-016 phy_reg_wr, phy_reg_rd  out  1 each  single-cycle start strobes.
REQ-017 mgmt_busy  in  1  transceiver busy.
REQ-018 phy_rd_data  in  16  transceiver read result.
REQ-019 result_valid  out  1  single-cycle pulse; read completed.
REQ-020 result_data  out  16  read data, held until the next read completes.
REQ-021 result_reg_addr  out  5  register address of the completed read.
REQ-022 timeout  out  1  single-cycle pulse; busy never asserted within START_TIMEOUT.
REQ-023 engine_busy  out  1  queue non-empty or FSM not in IDLE.

Function
REQ-024 Queue SHALL be a FIFO of DEPTH entries {is_write, md_addr, reg_addr, wr_data}, using wrapping pointers plus one extra bit for full/empty.
REQ-025 A push while queue_full SHALL be dropped and SHALL set overflow on the next cycle; if overflow_clr and a dropped push coincide, set wins.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when full (the pop frees the slot, so the push is accepted).
REQ-027 FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-028 IDLE: if the queue is non-empty and mgmt_busy=0, pop the head into the output registers and go to ISSUE; otherwise remain in IDLE.
REQ-029 ISSUE: assert exactly one of phy_reg_wr/phy_reg_rd for one cycle, per is_write; load the timeout counter with 0; go to WAIT_START.
REQ-030 WAIT_START: if mgmt_busy=1, go to WAIT_DONE; otherwise increment the counter, and when it reaches START_TIMEOUT pulse timeout and go to IDLE without result_valid.
REQ-031 WAIT_DONE: on mgmt_busy=0, go to IDLE. For a read, on the same cycle capture phy_rd_data into result_data, load result_reg_addr, and pulse result_valid.
REQ-032 Minimum spacing between strobes SHALL be one IDLE cycle after completion; back-to-back queued commands SHALL be issued without further gaps.
REQ-033 phy_* address and data outputs SHALL change only on the pop in IDLE.
REQ-034 The timeout counter width SHALL be $clog2(START_TIMEOUT+1) bits; it SHALL NOT wrap.

Reset
REQ-035 While rst_n=0: FIFO pointers cleared; queue_empty=1; queue_full=0; overflow=0; FSM=IDLE.
REQ-036 While rst_n=0: all strobes, result_valid and timeout=0; phy_* and result_* data outputs=0; engine_busy=0.
REQ-037 Reset asserted mid-transaction SHALL abandon the command and discard queue contents; no strobe SHALL be issued in the first cycle after release.

Verification
REQ-038 Single read (md 0x01, reg 0x02), with a busy model asserting 2 cycles after the strobe for 10 cycles and returning 0xBEEF -> one phy_reg_rd pulse; result_valid once with result_data=0xBEEF and result_reg_addr=0x02.
REQ-039 Push 4 writes in 4 consecutive cycles (DEPTH=4) with busy held high -> queue_full=1 after the 4th push; a 5th push sets overflow; the first strobe follows busy deassertion; writes are issued in order.
REQ-040 Busy never asserts -> timeout pulse exactly START_TIMEOUT+1 cycles after the strobe; FSM returns to IDLE; the next queued command issues.
REQ-041 Push and pop in the same cycle while full -> the entry is accepted, overflow stays 0, and the occupancy count is unchanged.
REQ-042 rst_n pulsed low during WAIT_DONE with 2 entries queued -> all outputs at reset values, queue_empty=1, and no strobes after release.
